// File: rtl/explosao_animada.sv
// explosao_animada: explosion animator driving HEX digits and red LEDs once
// the countdown reports TEMPO_ACABOU. Supports configurable digit/LED counts,
// a step prescaler (DIV), sync/chase/blink modes and an optional finite run
// (N_CICLOS > 0) that ends in a steady "detonated" frame flagged by FIM.
// Optional feature macro: EXPLOSAO_PISCAR_EN enables blink mode (MODO = 2);
// without it, MODO = 2 behaves as sync.
module explosao_animada #(
    parameter int N_HEX    = 8,
    parameter int N_LEDR   = 18,
    parameter int DIV      = 1,
    parameter int N_CICLOS = 0
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 TEMPO_ACABOU,
    input  logic [1:0]           MODO,
    output logic [7*N_HEX-1:0]   EXPLOSAO_HEX,
    output logic [N_LEDR-1:0]    EXPLOSAO_LEDR,
    output logic                 ATIVO,
    output logic                 FIM
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = (N_CICLOS > 0) ? $clog2(N_CICLOS + 1) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [CW-1:0] CICLO_ULT = (N_CICLOS > 0) ? CW'(N_CICLOS - 1) : '0;

    localparam logic [1:0] MODO_CHASE = 2'd1;
`ifdef EXPLOSAO_PISCAR_EN
    localparam logic [1:0] MODO_BLINK = 2'd2;
`endif

    typedef enum logic [1:0] {
        S_OCIOSO     = 2'd0,
        S_EXPLODINDO = 2'd1,
        S_FIM        = 2'd2
    } estado_t;

    estado_t         estado_q, estado_d;
    logic [1:0]      passo_q, passo_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [CW-1:0]   ciclo_q, ciclo_d;
    logic [1:0]      modo_q, modo_d;

    logic [7*N_HEX-1:0] hex_d;
    logic [N_LEDR-1:0]  ledr_d;
    logic               ativo_d;
    logic               fim_d;

    // Segment pattern for animation phase p (active-low segments).
    function automatic logic [6:0] padrao(input logic [1:0] p);
        case (p)
            2'd0:    return 7'b1111100;
            2'd1:    return 7'b1110011;
            2'd2:    return 7'b1001111;
            default: return 7'b0111111;
        endcase
    endfunction

    // State register.
    always_ff @(posedge CLOCK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its sources.
        if (RESET) estado_q <= S_OCIOSO;
        else       estado_q <= estado_d;
    end

    // Next state plus step/prescaler/cycle counters and the mode latch.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        estado_d = estado_q;
        passo_d  = passo_q;
        presc_d  = presc_q;
        ciclo_d  = ciclo_q;
        modo_d   = modo_q;
        case (estado_q)
            S_OCIOSO: begin
                if (TEMPO_ACABOU) begin
                    estado_d = S_EXPLODINDO;
                    passo_d  = '0;
                    presc_d  = '0;
                    ciclo_d  = '0;
                    modo_d   = MODO;
                end
            end
            S_EXPLODINDO: begin
                // Dropping the trigger wins over finishing on the same edge.
                if (!TEMPO_ACABOU) begin
                    estado_d = S_OCIOSO;
                end else if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    passo_d = passo_q + 2'd1;
                    if (passo_q == 2'd3) begin
                        ciclo_d = ciclo_q + CW'(1);
                        if (N_CICLOS > 0 && ciclo_q == CICLO_ULT)
                            estado_d = S_FIM;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            S_FIM: begin
                if (!TEMPO_ACABOU) estado_d = S_OCIOSO;
            end
            default: estado_d = S_OCIOSO;
        endcase
    end

    // Frame for the upcoming state, so the outputs can be registered with
    // no added latency.
    always_comb begin
        hex_d   = '1;
        ledr_d  = '0;
        ativo_d = 1'b0;
        fim_d   = 1'b0;
        case (estado_d)
            S_EXPLODINDO: begin
                ativo_d = 1'b1;
                for (int k = 0; k < N_HEX; k++)
                    hex_d[7*k +: 7] = padrao((modo_d == MODO_CHASE) ? passo_d + 2'(k) : passo_d);
                for (int i = 0; i < N_LEDR; i++)
                    ledr_d[i] = (2'(i) == passo_d);
`ifdef EXPLOSAO_PISCAR_EN
                if (modo_d == MODO_BLINK) begin
                    hex_d  = passo_d[0] ? '1 : '0;
                    ledr_d = passo_d[0] ? '0 : '1;
                end
`endif
            end
            S_FIM: begin
                hex_d  = '0;
                ledr_d = '1;
                fim_d  = 1'b1;
            end
            default: ;
        endcase
    end

    // Counters, mode latch and registered outputs.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            passo_q       <= '0;
            presc_q       <= '0;
            ciclo_q       <= '0;
            modo_q        <= '0;
            EXPLOSAO_HEX  <= '1;
            EXPLOSAO_LEDR <= '0;
            ATIVO         <= 1'b0;
            FIM           <= 1'b0;
        end else begin
            passo_q       <= passo_d;
            presc_q       <= presc_d;
            ciclo_q       <= ciclo_d;
            modo_q        <= modo_d;
            EXPLOSAO_HEX  <= hex_d;
            EXPLOSAO_LEDR <= ledr_d;
            ATIVO         <= ativo_d;
            FIM           <= fim_d;
        end
    end

endmodule

// File: tb/tb_explosao_animada.sv
// Testbench for explosao_animada: a table of stimulus/expected frames for the
// default configuration, checked through a scoreboard queue, plus hand-written
// sequences for the prescaled chase and the finite run.
module tb_explosao_animada;

    localparam logic [6:0] P0 = 7'b1111100;
    localparam logic [6:0] P1 = 7'b1110011;
    localparam logic [6:0] P2 = 7'b1001111;
    localparam logic [6:0] P3 = 7'b0111111;
    localparam logic [17:0] L0 = 18'h11111;
    localparam logic [17:0] L1 = 18'h22222;
    localparam logic [17:0] L2 = 18'h04444;
    localparam logic [17:0] L3 = 18'h08888;
    localparam logic [55:0] HEX_IDLE = {8{7'h7F}};

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        TEMPO_ACABOU;
    logic [1:0]  MODO;

    logic [55:0] hex_a, hex_b, hex_c;
    logic [17:0] ledr_a, ledr_b, ledr_c;
    logic        ativo_a, ativo_b, ativo_c;
    logic        fim_a, fim_b, fim_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLOCK = ~CLOCK;

    explosao_animada #(.N_HEX(8), .N_LEDR(18), .DIV(1), .N_CICLOS(0)) dut_a (
        .CLOCK(CLOCK), .RESET(RESET), .TEMPO_ACABOU(TEMPO_ACABOU), .MODO(MODO),
        .EXPLOSAO_HEX(hex_a), .EXPLOSAO_LEDR(ledr_a), .ATIVO(ativo_a), .FIM(fim_a));

    explosao_animada #(.N_HEX(8), .N_LEDR(18), .DIV(3), .N_CICLOS(0)) dut_b (
        .CLOCK(CLOCK), .RESET(RESET), .TEMPO_ACABOU(TEMPO_ACABOU), .MODO(MODO),
        .EXPLOSAO_HEX(hex_b), .EXPLOSAO_LEDR(ledr_b), .ATIVO(ativo_b), .FIM(fim_b));

    explosao_animada #(.N_HEX(8), .N_LEDR(18), .DIV(1), .N_CICLOS(2)) dut_c (
        .CLOCK(CLOCK), .RESET(RESET), .TEMPO_ACABOU(TEMPO_ACABOU), .MODO(MODO),
        .EXPLOSAO_HEX(hex_c), .EXPLOSAO_LEDR(ledr_c), .ATIVO(ativo_c), .FIM(fim_c));

    typedef struct {
        logic        rst;
        logic        tempo;
        logic [1:0]  modo;
        logic [6:0]  seg;
        logic [17:0] ledr;
        logic        ativo;
        logic        fim;
    } vec_t;

    typedef struct {
        logic [55:0] hex;
        logic [17:0] ledr;
        logic        ativo;
        logic        fim;
    } exp_t;

    localparam int N_VEC = 25;
    vec_t vecs [N_VEC];
    exp_t sb [$];

    function automatic vec_t mk(input logic rst, input logic tempo, input logic [1:0] modo,
                                input logic [6:0] seg, input logic [17:0] ledr,
                                input logic ativo, input logic fim);
        vec_t v;
        v.rst = rst; v.tempo = tempo; v.modo = modo;
        v.seg = seg; v.ledr = ledr; v.ativo = ativo; v.fim = fim;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one set of inputs, let one rising edge pass, sample just after it.
    task automatic drive(input logic rst, input logic tempo, input logic [1:0] modo);
        RESET        = rst;
        TEMPO_ACABOU = tempo;
        MODO         = modo;
        @(posedge CLOCK);
        #1;
    endtask

    initial begin
        exp_t e;
        RESET = 1'b1;
        TEMPO_ACABOU = 1'b0;
        MODO = 2'd0;

        // Default configuration: reset, idle, sync sequence, mode change
        // ignored, stop/restart, reset at step 2, blink, mode 3.
        vecs[0]  = mk(1, 0, 0, 7'h7F, 18'h0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 7'h7F, 18'h0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 7'h7F, 18'h0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 7'h7F, 18'h0, 0, 0);
        vecs[4]  = mk(0, 1, 0, P0, L0, 1, 0);
        vecs[5]  = mk(0, 1, 0, P1, L1, 1, 0);
        vecs[6]  = mk(0, 1, 0, P2, L2, 1, 0);
        vecs[7]  = mk(0, 1, 0, P3, L3, 1, 0);
        vecs[8]  = mk(0, 1, 0, P0, L0, 1, 0);
        vecs[9]  = mk(0, 1, 1, P1, L1, 1, 0);
        vecs[10] = mk(0, 1, 1, P2, L2, 1, 0);
        vecs[11] = mk(0, 0, 1, 7'h7F, 18'h0, 0, 0);
        vecs[12] = mk(0, 1, 0, P0, L0, 1, 0);
        vecs[13] = mk(0, 1, 0, P1, L1, 1, 0);
        vecs[14] = mk(0, 1, 0, P2, L2, 1, 0);
        vecs[15] = mk(1, 1, 0, 7'h7F, 18'h0, 0, 0);
        vecs[16] = mk(0, 0, 0, 7'h7F, 18'h0, 0, 0);
`ifdef EXPLOSAO_PISCAR_EN
        vecs[17] = mk(0, 1, 2, 7'h00, 18'h3FFFF, 1, 0);
        vecs[18] = mk(0, 1, 0, 7'h7F, 18'h0, 1, 0);
        vecs[19] = mk(0, 1, 0, 7'h00, 18'h3FFFF, 1, 0);
        vecs[20] = mk(0, 1, 0, 7'h7F, 18'h0, 1, 0);
`else
        vecs[17] = mk(0, 1, 2, P0, L0, 1, 0);
        vecs[18] = mk(0, 1, 0, P1, L1, 1, 0);
        vecs[19] = mk(0, 1, 0, P2, L2, 1, 0);
        vecs[20] = mk(0, 1, 0, P3, L3, 1, 0);
`endif
        vecs[21] = mk(0, 0, 0, 7'h7F, 18'h0, 0, 0);
        vecs[22] = mk(0, 1, 3, P0, L0, 1, 0);
        vecs[23] = mk(0, 1, 3, P1, L1, 1, 0);
        vecs[24] = mk(0, 0, 3, 7'h7F, 18'h0, 0, 0);

        for (int i = 0; i < N_VEC; i++) begin
            e.hex   = {8{vecs[i].seg}};
            e.ledr  = vecs[i].ledr;
            e.ativo = vecs[i].ativo;
            e.fim   = vecs[i].fim;
            sb.push_back(e);
            drive(vecs[i].rst, vecs[i].tempo, vecs[i].modo);
            e = sb.pop_front();
            check($sformatf("vec%0d hex", i),   64'(hex_a),   64'(e.hex));
            check($sformatf("vec%0d ledr", i),  64'(ledr_a),  64'(e.ledr));
            check($sformatf("vec%0d ativo", i), 64'(ativo_a), 64'(e.ativo));
            check($sformatf("vec%0d fim", i),   64'(fim_a),   64'(e.fim));
        end

        // Chase with DIV=3: each step held 3 clocks, digit k at phase passo+k.
        drive(1, 0, 0);
        drive(0, 0, 0);
        for (int j = 0; j < 3; j++) begin
            drive(0, 1, 1);
            check($sformatf("chase s0c%0d d0", j), 64'(hex_b[6:0]),  64'(P0));
            check($sformatf("chase s0c%0d d1", j), 64'(hex_b[13:7]), 64'(P1));
            check($sformatf("chase s0c%0d ativo", j), 64'(ativo_b), 64'(1'b1));
        end
        drive(0, 1, 1);
        check("chase s1 d0", 64'(hex_b[6:0]),   64'(P1));
        check("chase s1 d3", 64'(hex_b[27:21]), 64'(P0));
        check("chase s1 ledr", 64'(ledr_b), 64'(L1));
        drive(0, 1, 2);
        drive(0, 1, 2);
        check("chase s1 hold d0", 64'(hex_b[6:0]), 64'(P1));
        drive(0, 1, 2);
        check("chase s2 d0", 64'(hex_b[6:0]),   64'(P2));
        check("chase s2 d2", 64'(hex_b[20:14]), 64'(P0));
        check("chase s2 d7", 64'(hex_b[55:49]), 64'(P1));

        // Finite run, two cycles: FIM exactly 8 clocks after start.
        drive(1, 0, 0);
        drive(0, 0, 0);
        for (int j = 0; j < 8; j++) begin
            drive(0, 1, 0);
            check($sformatf("fin run%0d fim", j),   64'(fim_c),   64'(1'b0));
            check($sformatf("fin run%0d ativo", j), 64'(ativo_c), 64'(1'b1));
        end
        drive(0, 1, 0);
        check("fin fim",   64'(fim_c),   64'(1'b1));
        check("fin ativo", 64'(ativo_c), 64'(1'b0));
        check("fin hex",   64'(hex_c),   64'(56'h0));
        check("fin ledr",  64'(ledr_c),  64'(18'h3FFFF));
        drive(0, 1, 0);
        check("fin hold", 64'(fim_c), 64'(1'b1));
        drive(0, 0, 0);
        check("fin stop fim", 64'(fim_c), 64'(1'b0));
        check("fin stop hex", 64'(hex_c), 64'(HEX_IDLE));
        check("fin stop ledr", 64'(ledr_c), 64'(18'h0));

        // Trigger falls on the edge the last step completes: idle wins.
        for (int j = 0; j < 8; j++) drive(0, 1, 0);
        check("simul pre ativo", 64'(ativo_c), 64'(1'b1));
        drive(0, 0, 0);
        check("simul fim",   64'(fim_c),   64'(1'b0));
        check("simul ativo", 64'(ativo_c), 64'(1'b0));
        check("simul hex",   64'(hex_c),   64'(HEX_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
